wbu_queue: RTL

Parametrised writeback stage that succeeds the fixed-width, single-register writeback unit.
- Sits between the memory stage and the register file / CSR commit port.
- Buffers completed instructions in a DEPTH-entry FIFO under a valid/ready handshake on both sides, so the commit side can stall.
- Performs byte-lane extraction and sign/zero extension of load data for XLEN 32 or 64, selects the writeback value, and counts retired instructions.

---
 rtl/wbu_queue_if.sv | 54 +++++
 rtl/wbu_queue.sv | 135 +++++++++++++
 2 files changed

// File: rtl/wbu_queue_if.sv
// wbu_queue_if: bus between the memory stage, the writeback queue and the
// register-file / CSR commit port.
//   master : producer/consumer side (drives the *_in fields and commit_ready_in)
//   slave  : the wbu_queue stage itself (drives ready and the *_next outputs)
// XLEN   data width (32 or 64)
// CNT_W  retire counter width
interface wbu_queue_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  localparam int OFF_W = $clog2(XLEN / 8);

  // upstream side
  logic             valid_in;
  logic             ready;
  logic [XLEN-1:0]  mem_rdata_in;
  logic [OFF_W-1:0] addr_off_in;
  logic [2:0]       funct3_in;
  logic [XLEN-1:0]  ex_result_in;
  logic [XLEN-1:0]  rd_value_in;
  logic [4:0]       rd_in;
  logic [3:0]       csr_wen_in;
  logic             R_wen_in;
  logic             mem_ren_in;
  logic             jump_flag_in;
  logic [XLEN-1:0]  pc_in;

  // commit side
  logic             commit_ready_in;
  logic             valid_next;
  logic             R_wen_next;
  logic [3:0]       csr_wen_next;
  logic [XLEN-1:0]  csrd;
  logic [4:0]       rd_next;
  logic [XLEN-1:0]  rd_value_next;
  logic [XLEN-1:0]  pc_out;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output valid_in, mem_rdata_in, addr_off_in, funct3_in, ex_result_in,
           rd_value_in, rd_in, csr_wen_in, R_wen_in, mem_ren_in,
           jump_flag_in, pc_in, commit_ready_in,
    input  ready, valid_next, R_wen_next, csr_wen_next, csrd, rd_next,
           rd_value_next, pc_out, retire_cnt
  );

  modport slave (
    input  valid_in, mem_rdata_in, addr_off_in, funct3_in, ex_result_in,
           rd_value_in, rd_in, csr_wen_in, R_wen_in, mem_ren_in,
           jump_flag_in, pc_in, commit_ready_in,
    output ready, valid_next, R_wen_next, csr_wen_next, csrd, rd_next,
           rd_value_next, pc_out, retire_cnt
  );
endinterface

// File: rtl/wbu_queue.sv
// wbu_queue: buffered writeback stage. Completed instructions from the memory
// stage are held in a DEPTH-entry FIFO; the head entry has its load data
// byte-extracted and sign/zero extended, the writeback value selected, and is
// presented to the commit port. Every pop increments retire_cnt.
// Ports:
//   clock  clock
//   reset  synchronous active-high reset (drops all buffered entries)
//   bus    wbu_queue_if.slave: valid_in/ready upstream handshake plus entry
//          fields; valid_next/commit_ready_in commit handshake plus head
//          fields, writeback value and retire counter
// Parameters: XLEN (32/64), DEPTH (power of two >= 2), CNT_W (counter width)
module wbu_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 64
) (
  input  logic       clock,
  input  logic       reset,
  wbu_queue_if.slave bus
);
  localparam int OFF_W = $clog2(XLEN / 8);
  localparam int AW    = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]  mem_rdata;
    logic [OFF_W-1:0] addr_off;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  ex_result;
    logic [XLEN-1:0]  rd_value;
    logic [4:0]       rd;
    logic [3:0]       csr_wen;
    logic             r_wen;
    logic             mem_ren;
    logic             jump_flag;
    logic [XLEN-1:0]  pc;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [CNT_W-1:0] retire_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  wb_value;

  // ready/valid come only from registered count, so valid_in never reaches
  // an output combinationally and a full FIFO cannot accept in the pop cycle.
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.valid_in & ~full;
  assign pop   = ~empty & bus.commit_ready_in;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      retire_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        retire_q <= retire_q + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; stale contents are
  // unreachable because every head-derived output is masked while empty.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{
        mem_rdata: bus.mem_rdata_in,
        addr_off:  bus.addr_off_in,
        funct3:    bus.funct3_in,
        ex_result: bus.ex_result_in,
        rd_value:  bus.rd_value_in,
        rd:        bus.rd_in,
        csr_wen:   bus.csr_wen_in,
        r_wen:     bus.R_wen_in,
        mem_ren:   bus.mem_ren_in,
        jump_flag: bus.jump_flag_in,
        pc:        bus.pc_in
      };
    end
  end

  assign head = mem[rd_ptr];

  // NOTE: every always_comb output gets a default before the case/if so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    shifted   = head.mem_rdata >> {head.addr_off, 3'b000};
    load_data = '0;
    case (head.funct3)
      3'b000: load_data = XLEN'($signed(shifted[7:0]));
      3'b001: load_data = XLEN'($signed(shifted[15:0]));
      // for XLEN=32 the sign-extending cast is the identity, i.e. raw word
      3'b010: load_data = XLEN'($signed(shifted[31:0]));
      3'b100: load_data = XLEN'(shifted[7:0]);
      3'b101: load_data = XLEN'(shifted[15:0]);
      3'b110: if (XLEN == 64) load_data = XLEN'(shifted[31:0]);
      3'b011: if (XLEN == 64) load_data = shifted;
      default: load_data = '0;
    endcase

    // link / CSR-read value wins over load data, which wins over ALU result
    wb_value = head.ex_result;
    if (head.jump_flag || (|head.csr_wen)) wb_value = head.rd_value;
    else if (head.mem_ren)                 wb_value = load_data;
  end

  assign bus.ready         = ~full;
  assign bus.valid_next    = ~empty;
  assign bus.R_wen_next    = head.r_wen & ~empty;
  assign bus.csr_wen_next  = empty ? '0 : head.csr_wen;
  assign bus.csrd          = empty ? '0 : head.ex_result;
  assign bus.rd_next       = empty ? '0 : head.rd;
  assign bus.rd_value_next = empty ? '0 : wb_value;
  assign bus.pc_out        = empty ? '0 : head.pc;
  assign bus.retire_cnt    = retire_q;
endmodule
